simple_spi_master: RTL and testbench
====================================

# simple_spi_master

- SPI mode-0 initiator that shifts out one byte on MOSI while capturing one byte from MISO, then reports completion.
- Drives SCK, MOSI and CS_N from the board system clock for an external or on-chip SPI responder.
- Sits between internal control logic (start/busy/done handshake) and the SPI pins.
- Supports multi-byte frames by optionally holding CS_N low between bytes.

## Interface

- CLK_DIV, default 4: SCK half-period in CLK cycles; legal range 1..255.
- WIDTH, default 8: bits per transfer; MSB first.
- CLK  in  1: system clock; all logic on its rising edge.
- RST_N  in  1: asynchronous, active-low reset.
- start  in  1: request a transfer; accepted only when busy=0.
- tx_data  in  WIDTH: byte to send; sampled in the acceptance cycle.
- hold_cs  in  1: sampled with start; 1 keeps CS_N low after this transfer.
- cs_release  in  1: in IDLE with CS_N held low, deasserts CS_N on the next edge; ignored otherwise.
- rx_data  out  WIDTH: captured byte; updated only at done, stable until the next done.
- busy  out  1: transfer in progress.
- done  out  1: single-cycle completion pulse.
- SCK  out  1: SPI clock; idles low.
- MOSI  out  1: serial data out.
- MISO  in  1: serial data in; treated as synchronous to SCK.
- CS_N  out  1: chip select, active low.

## Operation

- States: IDLE, SHIFT_LO (SCK=0), SHIFT_HI (SCK=1), FINISH (SCK=0, last hold half-period).
- Reset (asynchronous, effective immediately, including mid-transfer): IDLE, SCK=0, MOSI=0, CS_N=1, busy=0, done=0, rx_data=0, divider=0, bit counter=0.
- IDLE + start: latch tx_data into the shift register and latch hold_cs. Assert CS_N=0 and busy=1. Drive MOSI=tx_data[WIDTH-1]. Go to SHIFT_LO.
- The divider counts CLK_DIV cycles per half-period. On terminal count it resets to 0 and the FSM advances.
- SHIFT_LO -> SHIFT_HI: SCK rises. MISO is sampled into the shift-register LSB on the same CLK edge.
- SHIFT_HI -> SHIFT_LO: SCK falls and MOSI advances to the next bit. This happens for bits 1..WIDTH-1.
- SHIFT_HI on bit WIDTH -> FINISH: SCK falls and MOSI holds the last bit.
- FINISH on terminal count -> IDLE:
  - rx_data is loaded, done=1 for one cycle, busy=0, MOSI=0.
  - CS_N=1 unless the latched hold_cs=1.
- start while busy=1: ignored; there is no queueing.
- start in the cycle done=1: accepted, because busy is already 0. The next transfer begins on that edge. If CS was held, CS_N stays low continuously with no glitch.
- cs_release and start in the same IDLE cycle: start wins and CS_N stays low.
- Arithmetic:
  - divider width is clog2(CLK_DIV+1).
  - bit counter width is clog2(WIDTH+1).
  - Both count up and compare for equality; they never wrap past terminal.

## Timing

- Edge 0 is the CLK edge that accepts start. Cycle n is the cycle after edge n.
- Edge 0: CS_N=0, busy=1, SCK=0, MOSI=bit WIDTH-1.
- Rising SCK edge k (k=1..WIDTH) occurs at edge (2k-1)·CLK_DIV. MISO is sampled at that same edge.
- Falling SCK edge k occurs at edge 2k·CLK_DIV.
- Edge (2·WIDTH+1)·CLK_DIV: done=1, busy=0, rx_data valid, CS_N deasserted if not held.
- Latency for WIDTH=8: 17·CLK_DIV CLK cycles from start acceptance to done.
- Setup and hold: MOSI is stable ≥ CLK_DIV cycles before and after each rising SCK edge. CS_N leads the first rising edge by CLK_DIV cycles and trails the last falling edge by CLK_DIV cycles.
- Exactly WIDTH rising SCK edges occur per transfer.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Structure

- Shared package/include simple_spi_pkg holds:
  - state encodings (IDLE=2'd0, SHIFT_LO=2'd1, SHIFT_HI=2'd2, FINISH=2'd3);
  - the default WIDTH;
  - the SPI mode-0 constants shared with responder-side blocks.
- One natural sub-module: spi_clk_div, a half-period tick generator with enable, parameterised by CLK_DIV. It is reset by RST_N and cleared when the FSM is in IDLE.
- FSM, shift register and bit counter stay in simple_spi_master.

## Test plan

- CLK_DIV=2, MISO looped to MOSI, start with tx_data=0xA5, hold_cs=0:
  - rx_data=0xA5;
  - done pulses at edge 34, exactly 1 cycle;
  - 8 SCK rising edges;
  - CS_N low from edge 0 to 34.
- CLK_DIV=1, MISO tied 1, tx_data=0x00:
  - MOSI stays 0 throughout, rx_data=0xFF, done at edge 17;
  - SCK period is 2 CLK.
- Back-to-back frame:
  - 0x3C with hold_cs=1, then 0xC3 with start asserted in the done cycle and hold_cs=0.
  - CS_N stays low across both bytes, with no high glitch.
  - rx_data matches each byte in turn (loopback).
  - CS_N rises with the second done.
- Held CS release:
  - After a hold_cs=1 transfer, idle 10 cycles with CS_N=0.
  - Pulse cs_release: CS_N=1 on the next edge.
  - cs_release while busy: no effect.
- start pulsed at edge 5 of a transfer: ignored. Only one done occurs, and rx_data is from the first byte.
- RST_N low during the 4th SCK high phase:
  - Immediate SCK=0, CS_N=1, MOSI=0, busy=0, done=0, rx_data=0.
  - After release, a fresh 0x5A transfer completes normally.

Source files
------------

// File: rtl/simple_spi_pkg.sv
// Shared definitions for the SPI mode-0 initiator and any responder-side blocks.
// Holds FSM state encodings, the default transfer width and the mode constants.
package simple_spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    FINISH   = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Mode 0: SCK idles low, data sampled on the rising edge, changed on the falling edge.
  localparam logic [1:0] SPI_MODE = 2'd0;
  localparam logic       SPI_CPOL = SPI_MODE[1];
  localparam logic       SPI_CPHA = SPI_MODE[0];
  localparam logic       SCK_IDLE = SPI_CPOL;
  localparam logic       CS_IDLE  = 1'b1;

  // SCK half-periods from start acceptance to the done pulse.
  function automatic int frame_half_periods(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/simple_spi_master_if.sv
// Control handshake and SPI pin bundle between internal logic and the SPI initiator.
// master is the initiator's view; slave is the view of whoever drives it.
interface simple_spi_master_if #(
  parameter int WIDTH = simple_spi_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] tx_data;
  logic             hold_cs;
  logic             cs_release;
  logic [WIDTH-1:0] rx_data;
  logic             busy;
  logic             done;
  logic             sck;
  logic             mosi;
  logic             miso;
  logic             cs_n;

  modport master (
    input  start, tx_data, hold_cs, cs_release, miso,
    output rx_data, busy, done, sck, mosi, cs_n
  );

  modport slave (
    output start, tx_data, hold_cs, cs_release, miso,
    input  rx_data, busy, done, sck, mosi, cs_n
  );

endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick is high in the last of every CLK_DIV enabled cycles.
// The count is held at zero whenever en is low so each frame starts on a fresh half-period.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int             CW   = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0]  TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next divider count: clear when disabled or at terminal, otherwise count up.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Divider count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == TERM);

endmodule

// File: rtl/simple_spi_master.sv
// SPI mode-0 initiator: shifts WIDTH bits MSB first on MOSI while capturing MISO,
// with optional CS_N hold between frames for multi-byte transactions.
module simple_spi_master
  import simple_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input logic                 clk,
  input logic                 rst_n,
  simple_spi_master_if.master bus
);

  localparam int            BW       = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             hold_q, hold_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;
  logic             div_en_s;
  logic             tick_s;

  assign div_en_s = (state_q != IDLE);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (div_en_s),
    .tick  (tick_s)
  );

  // Next-state and next-output logic for the transfer FSM.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT_LO;
          sreg_d  = bus.tx_data;
          hold_d  = bus.hold_cs;
          bit_d   = '0;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          mosi_d  = bus.tx_data[WIDTH-1];
        end else if (bus.cs_release) begin
          cs_n_d = CS_IDLE;
        end else begin
          cs_n_d = cs_n_q;
        end
      end
      SHIFT_LO: begin
        if (tick_s) begin
          state_d = SHIFT_HI;
          sck_d   = 1'b1;
          sreg_d  = {sreg_q[WIDTH-2:0], bus.miso};
          bit_d   = bit_q + BW'(1);
        end else begin
          state_d = SHIFT_LO;
        end
      end
      SHIFT_HI: begin
        if (tick_s) begin
          sck_d = SCK_IDLE;
          if (bit_q == LAST_BIT) begin
            state_d = FINISH;
          end else begin
            // The register has already shifted on the rising edge, so its MSB is the next bit.
            state_d = SHIFT_LO;
            mosi_d  = sreg_q[WIDTH-1];
          end
        end else begin
          state_d = SHIFT_HI;
        end
      end
      FINISH: begin
        if (tick_s) begin
          state_d = IDLE;
          rx_d    = sreg_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          mosi_d  = 1'b0;
          cs_n_d  = ~hold_q;
        end else begin
          state_d = FINISH;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        sck_d   = SCK_IDLE;
        mosi_d  = 1'b0;
        cs_n_d  = CS_IDLE;
      end
    endcase
  end

  // FSM state, datapath and registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sck_q   <= SCK_IDLE;
      mosi_q  <= 1'b0;
      cs_n_q  <= CS_IDLE;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign bus.rx_data = rx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sck     = sck_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_n_q;

endmodule

// File: tb/tb_simple_spi_master.sv
// Bench for simple_spi_master: lane 0 runs CLK_DIV=2, lane 1 runs CLK_DIV=1, both
// checked every cycle against an edge-timing model derived from the frame schedule.
module tb_simple_spi_master;

  localparam int W   = 8;
  localparam int CD0 = 2;
  localparam int CD1 = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [1:0]        start_v, hold_v, rel_v, loop_v, miso_v;
  logic [1:0][W-1:0] tx_v;

  simple_spi_master_if #(.WIDTH(W)) if0 ();
  simple_spi_master_if #(.WIDTH(W)) if1 ();

  assign if0.start      = start_v[0];
  assign if0.tx_data    = tx_v[0];
  assign if0.hold_cs    = hold_v[0];
  assign if0.cs_release = rel_v[0];
  assign if0.miso       = loop_v[0] ? if0.mosi : miso_v[0];
  assign if1.start      = start_v[1];
  assign if1.tx_data    = tx_v[1];
  assign if1.hold_cs    = hold_v[1];
  assign if1.cs_release = rel_v[1];
  assign if1.miso       = loop_v[1] ? if1.mosi : miso_v[1];

  simple_spi_master #(.CLK_DIV(CD0), .WIDTH(W)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  simple_spi_master #(.CLK_DIV(CD1), .WIDTH(W)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic [1:0]        o_busy, o_done, o_sck, o_mosi, o_cs_n;
  logic [1:0][W-1:0] o_rx;
  assign o_busy = {if1.busy, if0.busy};
  assign o_done = {if1.done, if0.done};
  assign o_sck  = {if1.sck,  if0.sck};
  assign o_mosi = {if1.mosi, if0.mosi};
  assign o_cs_n = {if1.cs_n, if0.cs_n};
  assign o_rx   = {if1.rx_data, if0.rx_data};

  // Model state: edges elapsed since acceptance, latched frame inputs, MISO samples.
  logic [1:0]        m_act, m_hold;
  int                m_e [2];
  logic [1:0][W-1:0] m_tx, m_acc;
  logic [1:0]        e_busy, e_done, e_sck, e_mosi, e_cs_n;
  logic [1:0][W-1:0] e_rx;

  int              r_lat, r_rises, r_cs_hi, r_mosi_hi;
  logic [W-1:0]    r_rx;
  logic            r_cs_done;

  task automatic chk(input string nm, input int l, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s lane%0d: got %0h want %0h at %0t", nm, l, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int   cd, ph, b;
    logic was_idle;
    if (!rst_n) begin
      m_act  = '0;
      e_busy = '0;
      e_done = '0;
      e_sck  = '0;
      e_mosi = '0;
      e_cs_n = '1;
      e_rx   = '0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        cd        = (l == 0) ? CD0 : CD1;
        was_idle  = !m_act[l];
        e_done[l] = 1'b0;
        if (m_act[l]) begin
          m_e[l]++;
          if ((m_e[l] % cd == 0) && ((m_e[l] / cd) % 2 == 1) && (m_e[l] / cd < 2 * W))
            m_acc[l] = {m_acc[l][W-2:0], (l == 0) ? if0.miso : if1.miso};
          if (m_e[l] == (2 * W + 1) * cd) begin
            m_act[l]  = 1'b0;
            e_done[l] = 1'b1;
            e_rx[l]   = m_acc[l];
            e_cs_n[l] = !m_hold[l];
          end
        end
        if (was_idle) begin
          if (start_v[l]) begin
            m_act[l]  = 1'b1;
            m_e[l]    = 0;
            m_tx[l]   = tx_v[l];
            m_hold[l] = hold_v[l];
            e_cs_n[l] = 1'b0;
          end else if (rel_v[l]) begin
            e_cs_n[l] = 1'b1;
          end
        end
        if (m_act[l]) begin
          ph = m_e[l] / cd;
          b  = m_e[l] / (2 * cd);
          if (b > W - 1) b = W - 1;
          e_busy[l] = 1'b1;
          e_sck[l]  = (ph % 2 == 1) && (ph < 2 * W);
          e_mosi[l] = m_tx[l][W-1-b];
        end else begin
          e_busy[l] = 1'b0;
          e_sck[l]  = 1'b0;
          e_mosi[l] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int l = 0; l < 2; l++) begin
      chk("busy",    l, W'(o_busy[l]), W'(e_busy[l]));
      chk("done",    l, W'(o_done[l]), W'(e_done[l]));
      chk("sck",     l, W'(o_sck[l]),  W'(e_sck[l]));
      chk("mosi",    l, W'(o_mosi[l]), W'(e_mosi[l]));
      chk("cs_n",    l, W'(o_cs_n[l]), W'(e_cs_n[l]));
      chk("rx_data", l, o_rx[l],       e_rx[l]);
    end
  endtask

  // One frame on lane l; optionally pokes start (kind 1) or cs_release (kind 2) while busy.
  task automatic xfer(input int l, input logic [W-1:0] tx, input logic hold,
                      input int poke_at, input int poke_kind);
    logic prev;
    start_v[l] = 1'b1;
    tx_v[l]    = tx;
    hold_v[l]  = hold;
    @(posedge clk);
    @(negedge clk);
    start_v[l] = 1'b0;
    rel_v[l]   = 1'b0;
    r_lat = 0; r_rises = 0; r_cs_hi = 0; r_mosi_hi = 0;
    prev = o_sck[l];
    while (r_lat < 400 && o_done[l] !== 1'b1) begin
      if (o_cs_n[l] !== 1'b0) r_cs_hi++;
      if (o_mosi[l] === 1'b1) r_mosi_hi++;
      start_v[l] = 1'b0;
      rel_v[l]   = 1'b0;
      if (r_lat == poke_at && poke_kind == 1) begin
        start_v[l] = 1'b1;
        tx_v[l]    = ~tx;
      end else if (r_lat == poke_at && poke_kind == 2) begin
        rel_v[l] = 1'b1;
      end
      @(negedge clk);
      r_lat++;
      if (o_sck[l] === 1'b1 && prev === 1'b0) r_rises++;
      prev = o_sck[l];
    end
    start_v[l] = 1'b0;
    rel_v[l]   = 1'b0;
    r_rx       = o_rx[l];
    r_cs_done  = o_cs_n[l];
    chk("done_seen", l, W'(o_done[l]), W'(1'b1));
  endtask

  initial begin
    int n;
    start_v = '0; hold_v = '0; rel_v = '0; loop_v = 2'b11; miso_v = '0; tx_v = '0;
    fork
      forever begin @(posedge clk or negedge rst_n); model_step(); end
      forever begin @(negedge clk); compare_all(); end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_sck",  0, W'(o_sck[0]),  W'(1'b0));
    chk("rst_cs_n", 0, W'(o_cs_n[0]), W'(1'b1));
    chk("rst_busy", 0, W'(o_busy[0]), W'(1'b0));
    chk("rst_rx",   1, o_rx[1],       8'h00);
    #2 rst_n = 1'b1;

    // Loopback 0xA5 at CLK_DIV=2.
    xfer(0, 8'hA5, 1'b0, -1, 0);
    chk("a5_rx", 0, r_rx, 8'hA5);
    chk("a5_lat", 0, W'(r_lat), 8'd34);
    chk("a5_rises", 0, W'(r_rises), 8'd8);
    chk("a5_cs_low", 0, W'(r_cs_hi), 8'd0);
    chk("a5_cs_done", 0, W'(r_cs_done), W'(1'b1));
    @(negedge clk);
    chk("a5_done_1cyc", 0, W'(o_done[0]), W'(1'b0));

    // MISO tied high, tx 0x00 at CLK_DIV=1.
    loop_v[1] = 1'b0; miso_v[1] = 1'b1;
    xfer(1, 8'h00, 1'b0, -1, 0);
    chk("ff_rx", 1, r_rx, 8'hFF);
    chk("ff_lat", 1, W'(r_lat), 8'd17);
    chk("ff_rises", 1, W'(r_rises), 8'd8);
    chk("ff_mosi0", 1, W'(r_mosi_hi), 8'd0);
    loop_v[1] = 1'b1;

    // Back-to-back frame with CS held across bytes.
    xfer(0, 8'h3C, 1'b1, -1, 0);
    chk("b2b1_rx", 0, r_rx, 8'h3C);
    chk("b2b1_cs_done", 0, W'(r_cs_done), W'(1'b0));
    xfer(0, 8'hC3, 1'b0, -1, 0);
    chk("b2b2_rx", 0, r_rx, 8'hC3);
    chk("b2b2_cs_low", 0, W'(r_cs_hi), 8'd0);
    chk("b2b2_cs_done", 0, W'(r_cs_done), W'(1'b1));

    // Held CS, release ignored while busy, then released from idle.
    xfer(0, 8'h66, 1'b1, 10, 2);
    chk("hold_cs_done", 0, W'(r_cs_done), W'(1'b0));
    n = 0;
    repeat (10) begin @(negedge clk); if (o_cs_n[0] !== 1'b0) n++; end
    chk("hold_idle_low", 0, W'(n), 8'd0);
    rel_v[0] = 1'b1;
    @(negedge clk);
    rel_v[0] = 1'b0;
    chk("release_cs", 0, W'(o_cs_n[0]), W'(1'b1));

    // start and cs_release together in idle with CS held: start wins.
    xfer(0, 8'h81, 1'b1, -1, 0);
    rel_v[0] = 1'b1;
    xfer(0, 8'h42, 1'b0, -1, 0);
    chk("startwins_cs_low", 0, W'(r_cs_hi), 8'd0);
    chk("startwins_rx", 0, r_rx, 8'h42);

    // start while busy is dropped.
    xfer(0, 8'h9B, 1'b0, 4, 1);
    chk("ign_rx", 0, r_rx, 8'h9B);
    n = 0;
    repeat (40) begin @(negedge clk); if (o_done[0] === 1'b1) n++; end
    chk("ign_no_2nd_done", 0, W'(n), 8'd0);

    // Randomized traffic on both lanes.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        start_v[l] = ($urandom_range(0, 5) == 0);
        tx_v[l]    = W'($urandom);
        hold_v[l]  = ($urandom_range(0, 1) == 1);
        rel_v[l]   = ($urandom_range(0, 7) == 0);
        loop_v[l]  = ($urandom_range(0, 1) == 1);
        miso_v[l]  = ($urandom_range(0, 1) == 1);
      end
    end
    start_v = '0; rel_v = '0; loop_v = 2'b11;
    repeat (60) @(negedge clk);

    // Reset during the 4th SCK high phase, then a fresh frame.
    xfer(0, 8'h77, 1'b0, -1, 0);
    start_v[0] = 1'b1; tx_v[0] = 8'h11; hold_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_rst_sck_hi", 0, W'(o_sck[0]), W'(1'b1));
    chk("pre_rst_mosi", 0, W'(o_mosi[0]), W'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sck",  0, W'(o_sck[0]),  W'(1'b0));
    chk("arst_cs_n", 0, W'(o_cs_n[0]), W'(1'b1));
    chk("arst_mosi", 0, W'(o_mosi[0]), W'(1'b0));
    chk("arst_busy", 0, W'(o_busy[0]), W'(1'b0));
    chk("arst_done", 0, W'(o_done[0]), W'(1'b0));
    chk("arst_rx",   0, o_rx[0],       8'h00);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    xfer(0, 8'h5A, 1'b0, -1, 0);
    chk("post_rst_rx", 0, r_rx, 8'h5A);
    chk("post_rst_lat", 0, W'(r_lat), 8'd34);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
